// File: rtl/pipe_mult_pkg.sv
// ---------------------------------------------------------------------------
// pipe_mult_pkg
//   Shared constants and helpers for the pipelined signed multiplier slice.
//   Holds the default operand widths / latency and the product-width rule so
//   the interface and the datapath size the result identically.
// ---------------------------------------------------------------------------
package pipe_mult_pkg;

  localparam int DEF_WIDTH_A = 16;
  localparam int DEF_WIDTH_B = 16;
  localparam int DEF_PIPELEN = 4;

  // Full-precision signed product width: no overflow for any operand pair,
  // including most-negative times most-negative.
  function automatic int prod_width(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/pipe_mult_if.sv
// ---------------------------------------------------------------------------
// pipe_mult_if
//   Operand/result bundle for pipe_mult.
//   en : clock enable for the whole pipe (driven by master)
//   a  : signed multiplicand, WIDTH_A bits (driven by master)
//   b  : signed multiplier, WIDTH_B bits (driven by master)
//   r  : signed full-precision product, WIDTH_A+WIDTH_B bits (driven by slave)
// ---------------------------------------------------------------------------
interface pipe_mult_if #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
) ();
  import pipe_mult_pkg::*;

  localparam int WIDTH_R = prod_width(WIDTH_A, WIDTH_B);

  logic                      en;
  logic signed [WIDTH_A-1:0] a;
  logic signed [WIDTH_B-1:0] b;
  logic signed [WIDTH_R-1:0] r;

  modport master (output en, output a, output b, input  r);
  modport slave  (input  en, input  a, input  b, output r);

endinterface

// File: rtl/pipe_mult_delay.sv
// ---------------------------------------------------------------------------
// pipe_mult_delay
//   Enabled shift chain of DEPTH registers, WIDTH bits each. Kept as plain
//   registers with no logic in between so synthesis can retime them into the
//   multiplier's internal pipeline registers.
//   clk : clock, rising edge
//   rst : synchronous active-high clear of every stage (wins over en)
//   en  : advance the chain; 0 holds every stage
//   d   : data into stage 0
//   q   : output of the last stage (registered)
// ---------------------------------------------------------------------------
module pipe_mult_delay #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] stage_r;

    if (i == 0) begin : g_head
      assign din_s = d;
    end else begin : g_tail
      assign din_s = g_stage[i-1].stage_r;
    end

    // One stage of the chain: clear on rst, shift on en, otherwise hold.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_r <= {WIDTH{1'b0}};
      end else if (en) begin
        stage_r <= din_s;
      end else begin
        stage_r <= stage_r;
      end
    end
  end

  assign q = g_stage[DEPTH-1].stage_r;

endmodule

// File: rtl/pipe_mult.sv
// ---------------------------------------------------------------------------
// pipe_mult
//   Fully pipelined signed multiplier r = a * b with full-precision result and
//   fixed latency of PIPELEN enabled edges (counting the sampling edge).
//   One operand pair per enabled edge; en=0 freezes the whole pipe.
//   clk : clock, rising edge
//   rst : synchronous active-high clear of all stages and r (wins over en)
//   bus : pipe_mult_if slave port (en, a, b in; r out, registered)
// Parameters: WIDTH_A, WIDTH_B operand widths; PIPELEN latency (>= 1).
// ---------------------------------------------------------------------------
module pipe_mult
  import pipe_mult_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int PIPELEN = DEF_PIPELEN
) (
  input  logic      clk,
  input  logic      rst,
  pipe_mult_if.slave bus
);

  localparam int WIDTH_R = prod_width(WIDTH_A, WIDTH_B);

  // Sign-extend both operands to the product width before multiplying; the
  // low WIDTH_R bits of that product are the exact signed result.
  function automatic logic signed [WIDTH_R-1:0] mul_full(
    input logic signed [WIDTH_A-1:0] op_a,
    input logic signed [WIDTH_B-1:0] op_b
  );
    logic signed [WIDTH_R-1:0] ext_a;
    logic signed [WIDTH_R-1:0] ext_b;
    ext_a = {{WIDTH_B{op_a[WIDTH_A-1]}}, op_a};
    ext_b = {{WIDTH_A{op_b[WIDTH_B-1]}}, op_b};
    return ext_a * ext_b;
  endfunction

  logic signed [WIDTH_R-1:0] r_s;

  if (PIPELEN == 1) begin : g_single
    logic signed [WIDTH_R-1:0] r_r;

    // Single-stage case: product of the raw inputs registered straight into r.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_r <= {WIDTH_R{1'b0}};
      end else if (bus.en) begin
        r_r <= mul_full(bus.a, bus.b);
      end else begin
        r_r <= r_r;
      end
    end

    assign r_s = r_r;
  end else begin : g_multi
    logic signed [WIDTH_A-1:0] a_r;
    logic signed [WIDTH_B-1:0] b_r;
    logic signed [WIDTH_R-1:0] prod_s;

    // Operand stage: the sampling edge of the latency count.
    always_ff @(posedge clk) begin
      if (rst) begin
        a_r <= {WIDTH_A{1'b0}};
        b_r <= {WIDTH_B{1'b0}};
      end else if (bus.en) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end else begin
        a_r <= a_r;
        b_r <= b_r;
      end
    end

    assign prod_s = mul_full(a_r, b_r);

    // Remaining PIPELEN-1 stages; the last one is the r register.
    pipe_mult_delay #(
      .WIDTH (WIDTH_R),
      .DEPTH (PIPELEN - 1)
    ) u_delay (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .d   (prod_s),
      .q   (r_s)
    );
  end

  assign bus.r = r_s;

endmodule

// File: tb/tb_pipe_mult.sv
// ---------------------------------------------------------------------------
// tb_pipe_mult
//   Scoreboard bench for pipe_mult (16x28, PIPELEN=10) with a PIPELEN=1
//   instance sharing the same stimulus. Directed vectors carry hand-computed
//   products; a recorder pushes them at each enabled edge and a monitor pops
//   and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_mult;

  localparam int WA = 16;
  localparam int WB = 28;
  localparam int WR = WA + WB;
  localparam int PL = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_mult_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus10 ();
  pipe_mult_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus1 ();

  pipe_mult #(.WIDTH_A(WA), .WIDTH_B(WB), .PIPELEN(PL)) u_dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );

  pipe_mult #(.WIDTH_A(WA), .WIDTH_B(WB), .PIPELEN(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic signed [WA-1:0] drv_a;
  logic signed [WB-1:0] drv_b;
  logic                 drv_en;
  logic                 drv_rst;
  logic signed [WR-1:0] drv_exp;

  assign rst      = drv_rst;
  assign bus10.a  = drv_a;
  assign bus10.b  = drv_b;
  assign bus10.en = drv_en;
  assign bus1.a   = drv_a;
  assign bus1.b   = drv_b;
  assign bus1.en  = drv_en;

  logic signed [WR-1:0] sb[$];
  logic signed [WR-1:0] exp_r;
  logic signed [WR-1:0] exp1;
  int kind = 0;   // 0 none yet, 1 enabled edge, 2 stalled edge, 3 reset edge
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [WR-1:0] act,
                       input logic signed [WR-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input longint a, input longint b, input logic en,
                      input logic rs, input longint e);
    drv_a   = a[WA-1:0];
    drv_b   = b[WB-1:0];
    drv_en  = en;
    drv_rst = rs;
    drv_exp = e[WR-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b1, 1'b0, 0);
  endtask

  // Recorder: pushes the expected product for every sampled operand pair.
  initial begin
    exp1 = '0;
    forever begin
      @(posedge clk);
      if (drv_rst) begin
        sb.delete();
        for (int i = 0; i < PL - 1; i++) sb.push_back('0);
        exp1 = '0;
        kind = 3;
      end else if (drv_en) begin
        sb.push_back(drv_exp);
        exp1 = drv_exp;
        kind = 1;
      end else begin
        kind = 2;
      end
    end
  end

  // Monitor: after each edge pop (or hold) the expected value and compare.
  initial begin
    exp_r = '0;
    forever begin
      @(negedge clk);
      if (kind == 1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_underflow at %0t: got empty queue expected an entry", $time);
        end else begin
          exp_r = sb.pop_front();
        end
      end else if (kind == 3) begin
        exp_r = '0;
      end
      if (kind != 0) begin
        check("r_pipelen10", bus10.r, exp_r);
        check("r_pipelen1", bus1.r, exp1);
      end
    end
  end

  initial begin
    drv_a = '0; drv_b = '0; drv_en = 1'b1; drv_rst = 1'b1; drv_exp = '0;
    step(0, 0, 1'b1, 1'b1, 0);
    step(0, 0, 1'b1, 1'b1, 0);
    idle(3);

    // Single product; r must stay 0 until exactly the 10th edge.
    step(16384, 16384, 1'b1, 1'b0, 268435456);
    idle(12);

    // Extremes, back to back.
    step(-32768, -134217728, 1'b1, 1'b0, 64'sd4398046511104);
    step(-32768, 134217727, 1'b1, 1'b0, -64'sd4398046478336);
    step(32767, -1, 1'b1, 1'b0, -32767);
    step(-5, 7, 1'b1, 1'b0, -35);
    idle(12);

    // Streaming 1..20 times -3, no bubbles.
    for (int i = 1; i <= 20; i++) step(i, -3, 1'b1, 1'b0, -3 * i);
    idle(12);

    // Stream with a 7-cycle stall mid-way; junk inputs during the stall.
    for (int i = 1; i <= 8; i++) step(i, -3, 1'b1, 1'b0, -3 * i);
    for (int i = 0; i < 7; i++) step(999, 12345, 1'b0, 1'b0, 0);
    for (int i = 9; i <= 20; i++) step(i, -3, 1'b1, 1'b0, -3 * i);
    idle(12);

    // Reset with 5 products in flight, en=1 (operand on reset edge dropped).
    for (int i = 1; i <= 5; i++) step(100 + i, 2, 1'b1, 1'b0, 2 * (100 + i));
    step(55, 55, 1'b1, 1'b1, 0);
    step(7, 9, 1'b1, 1'b0, 63);
    idle(12);

    // Reset with 5 products in flight, en=0.
    for (int i = 1; i <= 5; i++) step(-200 - i, 3, 1'b1, 1'b0, -3 * (200 + i));
    step(0, 0, 1'b0, 1'b1, 0);
    step(-11, -13, 1'b1, 1'b0, 143);
    idle(12);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
